alu_bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits between the ALU result register and the per-digit BCD-to-7-segment decoders. It takes a WIDTH-bit ALU result, either unsigned or two's-complement, and produces DIGITS packed BCD digits plus a sign flag. Each digit nibble drives one 7-segment decoder directly and is always in the range 0..9.

---
 rtl/alu_disp_pkg.sv | 14 +
 rtl/alu_bin2bcd_seq_if.sv | 36 +++
 rtl/bcd_add3.sv | 16 +
 rtl/alu_bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_alu_bin2bcd_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display path.
// Used by the binary-to-BCD converter and its digit adjust cells.
package alu_disp_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 5;
  localparam int BCD_MAX_DIGIT  = 9;

endpackage

// File: rtl/alu_bin2bcd_seq_if.sv
// Request/result bundle between the ALU result register
// and the BCD converter feeding the 7-segment decoders.
interface alu_bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;

  modport master (
    output start,
    output bin_in,
    output signed_mode,
    input  busy,
    input  done,
    input  bcd,
    input  neg
  );

  modport slave (
    input  start,
    input  bin_in,
    input  signed_mode,
    output busy,
    output done,
    output bcd,
    output neg
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD nibble
// that is 5 or more, so the following shift carries correctly.
module bcd_add3
  import alu_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_DIGIT_W'(ADD3_THRESHOLD))
      d_o = d_i + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/alu_bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with
// optional two's-complement input and a separate sign flag.
module alu_bin2bcd_seq
  import alu_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_bin2bcd_seq_if.slave  io
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [SCR_W-1:0] scr_q, scr_d;
  logic [SCR_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCR_W-1:0] bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] neg_mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // -2^(WIDTH-1) negates to itself, which is the correct magnitude
  assign neg_mag = WIDTH'(0) - io.bin_in;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          if (io.signed_mode && io.bin_in[WIDTH-1]) begin
            mag_d  = neg_mag;
            sign_d = 1'b1;
          end else begin
            mag_d  = io.bin_in;
            sign_d = 1'b0;
          end
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, mag_d} = {adj[SCR_W-2:0], mag_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_d;
          neg_d   = sign_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign io.neg  = neg_q;

endmodule

// File: tb/tb_alu_bin2bcd_seq.sv
// Directed self-checking bench for alu_bin2bcd_seq.
module tb_alu_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   dcnt;
  logic [11:0] exp_bcd;

  alu_bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) io ();

  alu_bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done(output int n);
    n = 0;
    while (io.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns at the negedge where done is visible.
  task automatic conv(input logic [7:0] b, input logic sm,
                      input string tag);
    int n;
    @(negedge clk);
    io.start = 1'b1;
    io.bin_in = b;
    io.signed_mode = sm;
    @(negedge clk);
    io.start = 1'b0;
    io.bin_in = 8'($urandom);
    io.signed_mode = 1'($urandom);
    chk({tag, " busy"}, 32'(io.busy), 32'd1);
    wait_done(n);
    chk({tag, " latency"}, n, 32'd8);
  endtask

  task automatic count_dones(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (io.done === 1'b1) c++;
    end
  endtask

  initial begin
    io.start = 1'b0;
    io.bin_in = '0;
    io.signed_mode = 1'b0;
    #1;
    chk("reset busy", 32'(io.busy), 32'd0);
    chk("reset done", 32'(io.done), 32'd0);
    chk("reset bcd", 32'(io.bcd), 32'd0);
    chk("reset neg", 32'(io.neg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    conv(8'd0, 1'b0, "u0");
    chk("u0 bcd", 32'(io.bcd), 32'h000);
    chk("u0 neg", 32'(io.neg), 32'd0);
    chk("u0 busy at done", 32'(io.busy), 32'd0);
    @(negedge clk);
    chk("u0 done one cycle", 32'(io.done), 32'd0);

    conv(8'd255, 1'b0, "u255");
    chk("u255 bcd", 32'(io.bcd), 32'h255);
    chk("u255 neg", 32'(io.neg), 32'd0);

    conv(8'hFF, 1'b0, "uFF nosign");
    chk("uFF neg", 32'(io.neg), 32'd0);

    conv(8'h80, 1'b1, "s80");
    chk("s80 bcd", 32'(io.bcd), 32'h128);
    chk("s80 neg", 32'(io.neg), 32'd1);
    conv(8'hFF, 1'b1, "sFF");
    chk("sFF bcd", 32'(io.bcd), 32'h001);
    chk("sFF neg", 32'(io.neg), 32'd1);
    conv(8'h7F, 1'b1, "s7F");
    chk("s7F bcd", 32'(io.bcd), 32'h127);
    chk("s7F neg", 32'(io.neg), 32'd0);
    conv(8'h00, 1'b1, "s00");
    chk("s00 bcd", 32'(io.bcd), 32'h000);
    chk("s00 neg", 32'(io.neg), 32'd0);

    for (int v = 0; v < 256; v++) begin
      conv(8'(v), 1'b0, "sweep");
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      chk("sweep bcd", 32'(io.bcd), 32'(exp_bcd));
      chk("sweep nibble", 32'(io.bcd[11:8] <= 4'd9 &&
                              io.bcd[7:4] <= 4'd9 &&
                              io.bcd[3:0] <= 4'd9), 32'd1);
    end

    // start pulse mid-conversion must be dropped
    @(negedge clk);
    io.start = 1'b1;
    io.bin_in = 8'd9;
    io.signed_mode = 1'b0;
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    io.start = 1'b1;
    io.bin_in = 8'd200;
    @(negedge clk);
    io.start = 1'b0;
    wait_done(lat);
    chk("ignore done seen", 32'(io.done), 32'd1);
    chk("ignore bcd", 32'(io.bcd), 32'h009);
    count_dones(20, dcnt);
    chk("ignore no 2nd done", dcnt, 32'd0);

    // back-to-back: restart in the done cycle
    conv(8'd42, 1'b0, "b2b first");
    chk("b2b first bcd", 32'(io.bcd), 32'h042);
    chk("b2b busy low", 32'(io.busy), 32'd0);
    io.start = 1'b1;
    io.bin_in = 8'd99;
    io.signed_mode = 1'b0;
    @(negedge clk);
    io.start = 1'b0;
    chk("b2b busy back", 32'(io.busy), 32'd1);
    chk("b2b done dropped", 32'(io.done), 32'd0);
    wait_done(lat);
    chk("b2b second latency", lat, 32'd8);
    chk("b2b second bcd", 32'(io.bcd), 32'h099);

    // reset aborts an in-flight conversion
    conv(8'hFB, 1'b1, "pre-rst");
    chk("pre-rst bcd", 32'(io.bcd), 32'h005);
    chk("pre-rst neg", 32'(io.neg), 32'd1);
    @(negedge clk);
    io.start = 1'b1;
    io.bin_in = 8'd77;
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst bcd", 32'(io.bcd), 32'd0);
    chk("rst neg", 32'(io.neg), 32'd0);
    chk("rst busy", 32'(io.busy), 32'd0);
    chk("rst done", 32'(io.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(20, dcnt);
    chk("rst no done", dcnt, 32'd0);
    conv(8'd33, 1'b0, "post-rst");
    chk("post-rst bcd", 32'(io.bcd), 32'h033);
    chk("post-rst neg", 32'(io.neg), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
